// File: rtl/ram_helper_arbiter_if.sv
// Requester-side bus of ram_helper_arbiter: per-port request handshake plus
// the shared one-cycle-latency response. Per-port 64-bit fields are packed
// with port i in bits [64i+63:64i].
interface ram_helper_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_wen;
  logic [NREQ*64-1:0]   req_idx;
  logic [NREQ*64-1:0]   req_wdata;
  logic [NREQ*64-1:0]   req_wmask;
  logic [NREQ-1:0]      resp_valid;
  logic [63:0]          resp_rdata;

  modport master (
    output req_valid, req_wen, req_idx, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_idx, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ram_helper_arbiter.sv
// Round-robin arbiter sharing a single RAMHelper port among NREQ requesters.
// At most one read or one write is issued per cycle; every handshake gets a
// resp_valid pulse exactly one cycle later (read data or write ack).
// Optional feature macro RAM_ARB_PERF_EN adds per-port grant counters
// (perf_grant_cnt, PERF_CNT_W bits each) and prints their totals at end of sim.
module ram_helper_arbiter #(
  parameter int unsigned NREQ = 4
`ifdef RAM_ARB_PERF_EN
  ,
  parameter int unsigned PERF_CNT_W = 32
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ram_helper_arbiter_if.slave    req_bus,
  output logic [63:0]            ram_rIdx,
  input  logic [63:0]            ram_rdata,
  output logic [63:0]            ram_wIdx,
  output logic [63:0]            ram_wdata,
  output logic [63:0]            ram_wmask,
  output logic                   ram_wen
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [NREQ*PERF_CNT_W-1:0] perf_grant_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  resp_vld_q, resp_vld_d;
  logic             resp_wr_q, resp_wr_d;

  logic             gnt_vld;
  logic [PTR_W-1:0] gnt_idx;
  logic [NREQ-1:0]  grant;

  // Pick the first valid requester starting at rr_ptr; nothing is granted in reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (rst_n) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!gnt_vld && req_bus.req_valid[(32'(rr_ptr_q) + k) % NREQ]) begin
          gnt_vld = 1'b1;
          gnt_idx = PTR_W'((32'(rr_ptr_q) + k) % NREQ);
        end
      end
    end
    grant = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant[i] = gnt_vld && (32'(gnt_idx) == i);
    end
  end

  assign req_bus.req_ready = grant;

  // Steer the granted request onto exactly one of the RAM read or write ports.
  always_comb begin
    ram_rIdx  = '0;
    ram_wIdx  = '0;
    ram_wdata = '0;
    ram_wmask = '0;
    ram_wen   = 1'b0;
    if (gnt_vld) begin
      if (req_bus.req_wen[gnt_idx]) begin
        ram_wen   = 1'b1;
        ram_wIdx  = req_bus.req_idx[64*32'(gnt_idx) +: 64];
        ram_wdata = req_bus.req_wdata[64*32'(gnt_idx) +: 64];
        ram_wmask = req_bus.req_wmask[64*32'(gnt_idx) +: 64];
      end else begin
        ram_rIdx  = req_bus.req_idx[64*32'(gnt_idx) +: 64];
      end
    end
  end

  // Next pointer and response pipeline stage.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    resp_vld_d = grant;
    resp_wr_d  = gnt_vld && req_bus.req_wen[gnt_idx];
    if (gnt_vld) begin
      rr_ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      resp_vld_q <= '0;
      resp_wr_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      resp_vld_q <= resp_vld_d;
      resp_wr_q  <= resp_wr_d;
    end
  end

  // Masking with rst_n drops a response whose handshake preceded a reset.
  assign req_bus.resp_valid = resp_vld_q & {NREQ{rst_n}};
  assign req_bus.resp_rdata = resp_wr_q ? '0 : ram_rdata;

`ifdef RAM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] cnt_q [NREQ];
  logic [PERF_CNT_W-1:0] cnt_d [NREQ];

  // Per-port handshake counters, wrapping naturally at 2^PERF_CNT_W.
  always_comb begin
    perf_grant_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i] + PERF_CNT_W'(grant[i]);
      perf_grant_cnt[i*PERF_CNT_W +: PERF_CNT_W] = cnt_q[i];
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!rst_n) cnt_q[i] <= '0;
      else        cnt_q[i] <= cnt_d[i];
    end
  end

  final begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      $display("ram_helper_arbiter: port %0d grants=%0d", i, cnt_q[i]);
    end
  end
`endif

endmodule

// File: tb/tb_ram_helper_arbiter.sv
// Directed testbench for ram_helper_arbiter with a behavioural RAMHelper
// model (masked write at the edge, registered read one cycle later).
module tb_ram_helper_arbiter;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_helper_arbiter_if #(.NREQ(NREQ)) bus ();

  logic [63:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;
  logic        ram_wen;

`ifdef RAM_ARB_PERF_EN
  logic [NREQ*4-1:0] perf_grant_cnt;
  ram_helper_arbiter #(.NREQ(NREQ), .PERF_CNT_W(4)) dut (
`else
  ram_helper_arbiter #(.NREQ(NREQ)) dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .req_bus   (bus),
    .ram_rIdx  (ram_rIdx),
    .ram_rdata (ram_rdata),
    .ram_wIdx  (ram_wIdx),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .ram_wen   (ram_wen)
`ifdef RAM_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt)
`endif
  );

  // RAMHelper model
  logic [63:0] mem [logic [63:0]];
  initial ram_rdata = '0;
  always @(posedge clk) begin
    logic [63:0] old;
    if (ram_wen) begin
      old = mem.exists(ram_wIdx) ? mem[ram_wIdx] : 64'h0;
      mem[ram_wIdx] = (old & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
    ram_rdata <= mem.exists(ram_rIdx) ? mem[ram_rIdx] : 64'h0;
  end

  int checks = 0;
  int failures = 0;
  int gcnt [NREQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.req_valid = '0;
    bus.req_wen   = '0;
    bus.req_idx   = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
  endtask

  task automatic drive(input int p, input logic wen, input logic [63:0] idx,
                       input logic [63:0] wd, input logic [63:0] wm);
    bus.req_valid[p]          = 1'b1;
    bus.req_wen[p]            = wen;
    bus.req_idx[64*p +: 64]   = idx;
    bus.req_wdata[64*p +: 64] = wd;
    bus.req_wmask[64*p +: 64] = wm;
  endtask

  initial begin
    idle_all();

    // 1: reset with all requesters valid
    rst_n = 1'b0;
    bus.req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rst_ready", 64'(bus.req_ready), 64'h0);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
      check("rst_ram_wen", 64'(ram_wen), 64'h0);
      step();
    end
    rst_n = 1'b1;
    #1;
    check("post_rst_first_grant", 64'(bus.req_ready), 64'h1);
    step();
    idle_all();
    #1;
    check("post_rst_resp", 64'(bus.resp_valid), 64'h1);
    check("idle_ready", 64'(bus.req_ready), 64'h0);

    // 2: port 2 write then read of idx 0x10
    drive(2, 1'b1, 64'h10, 64'hDEADBEEF, '1);
    #1;
    check("wr_ready", 64'(bus.req_ready), 64'h4);
    check("wr_ram_wen", 64'(ram_wen), 64'h1);
    check("wr_ram_wIdx", ram_wIdx, 64'h10);
    check("wr_ram_wdata", ram_wdata, 64'hDEADBEEF);
    check("wr_ram_rIdx", ram_rIdx, 64'h0);
    step();
    drive(2, 1'b0, 64'h10, 64'h0, 64'h0);
    #1;
    check("wr_resp_valid", 64'(bus.resp_valid), 64'h4);
    check("wr_resp_rdata", bus.resp_rdata, 64'h0);
    check("rd_ready", 64'(bus.req_ready), 64'h4);
    check("rd_ram_rIdx", ram_rIdx, 64'h10);
    check("rd_ram_wen", 64'(ram_wen), 64'h0);
    step();
    idle_all();
    #1;
    check("rd_resp_valid", 64'(bus.resp_valid), 64'h4);
    check("rd_resp_rdata", bus.resp_rdata, 64'hDEADBEEF);
    check("idle_ram_wen", 64'(ram_wen), 64'h0);
    check("idle_ram_rIdx", ram_rIdx, 64'h0);
    check("idle_ram_wIdx", ram_wIdx, 64'h0);
    step();

    // 3: fairness with all ports valid for 12 cycles, starting from rr_ptr=0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) gcnt[i] = 0;
    for (int k = 0; k < 12; k++) begin
      for (int p = 0; p < int'(NREQ); p++) drive(p, 1'b0, 64'(k), 64'h0, 64'h0);
      #1;
      check($sformatf("rr_grant_%0d", k), 64'(bus.req_ready), 64'(1) << (k % 4));
      if (k > 0) check($sformatf("rr_resp_%0d", k), 64'(bus.resp_valid), 64'(1) << ((k - 1) % 4));
      for (int p = 0; p < int'(NREQ); p++) gcnt[p] += int'(bus.req_ready[p]);
      step();
    end
    idle_all();
    #1;
    check("rr_last_resp", 64'(bus.resp_valid), 64'h8);
    for (int p = 0; p < int'(NREQ); p++) check($sformatf("rr_count_%0d", p), 64'(gcnt[p]), 64'd3);
    step();

    // 4: partial write mask
    drive(1, 1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    check("pm_pre_ready", 64'(bus.req_ready), 64'h2);
    step();
    drive(1, 1'b1, 64'h20, 64'h0, 64'h0000_0000_FFFF_FFFF);
    #1;
    check("pm_wmask", ram_wmask, 64'h0000_0000_FFFF_FFFF);
    step();
    drive(1, 1'b0, 64'h20, 64'h0, 64'h0);
    #1;
    check("pm_rIdx", ram_rIdx, 64'h20);
    step();
    idle_all();
    #1;
    check("pm_resp_valid", 64'(bus.resp_valid), 64'h2);
    check("pm_rdata", bus.resp_rdata, 64'hFFFF_FFFF_0000_0000);
    step();

    // 5: reset while a read response is in flight
    drive(3, 1'b0, 64'h10, 64'h0, 64'h0);
    #1;
    check("mid_ready", 64'(bus.req_ready), 64'h8);
    step();
    rst_n = 1'b0;
    bus.req_valid = '1;
    #1;
    check("mid_resp_dropped", 64'(bus.resp_valid), 64'h0);
    check("mid_rst_ready", 64'(bus.req_ready), 64'h0);
    check("mid_rst_wen", 64'(ram_wen), 64'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_ptr_zero", 64'(bus.req_ready), 64'h1);
    check("mid_no_resp", 64'(bus.resp_valid), 64'h0);
    step();
    idle_all();
    step();

`ifdef RAM_ARB_PERF_EN
    // 6: 4-bit grant counter wraps after 16 grants
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(1, 1'b0, 64'h0, 64'h0, 64'h0);
    repeat (17) step();
    idle_all();
    #1;
    check("perf_cnt0", 64'(perf_grant_cnt[3:0]), 64'd0);
    check("perf_cnt1", 64'(perf_grant_cnt[7:4]), 64'd1);
    check("perf_cnt2", 64'(perf_grant_cnt[11:8]), 64'd0);
    check("perf_cnt3", 64'(perf_grant_cnt[15:12]), 64'd0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
